// File: rtl/carp_sim_pkg.sv
// Shared definitions for the CARP run controller: run-state encoding and tohost mailbox constants.
package carp_sim_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RESET   = 3'd1,
      ST_RUN     = 3'd2,
      ST_DONE    = 3'd3,
      ST_TIMEOUT = 3'd4
   } run_state_t;

   localparam logic [31:0] TOHOST_PASS         = 32'd1;
   localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_1000;

   function automatic logic is_terminal(input run_state_t s);
      return (s == ST_DONE) || (s == ST_TIMEOUT);
   endfunction

endpackage

// File: rtl/carp_tohost_mon.sv
// Single-hart tohost detector: latches the first odd-valued store to the mailbox while enabled,
// and exposes this cycle's qualifying write so the controller can act on the same edge.
module carp_tohost_mon
   import carp_sim_pkg::*;
#(
   parameter int                 ADDR_W      = 32,
   parameter int                 DATA_W      = 32,
   parameter logic [ADDR_W-1:0]  TOHOST_ADDR = ADDR_W'(DEFAULT_TOHOST_ADDR)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic              done_o,
   output logic              fail_o,
   output logic [DATA_W-1:0] code_o,
   output logic              hit_o,
   output logic              hit_fail_o,
   output logic [DATA_W-1:0] hit_code_o
);

   logic              done_q, fail_q;
   logic [DATA_W-1:0] code_q;
   logic              done_d, fail_d;
   logic [DATA_W-1:0] code_d;
   logic              hit_s, hit_fail_s;
   logic [DATA_W-1:0] hit_code_s;

   // Even data is a console/heartbeat write, not a completion, so bit 0 qualifies the store.
   always_comb begin
      hit_s      = en_i & we_i & ~done_q & (addr_i == TOHOST_ADDR) & wdata_i[0];
      hit_fail_s = (wdata_i != DATA_W'(TOHOST_PASS));
      hit_code_s = hit_fail_s ? (wdata_i >> 1) : '0;
      if (hit_s) begin
         done_d = 1'b1;
         fail_d = hit_fail_s;
         code_d = hit_code_s;
      end else begin
         done_d = done_q;
         fail_d = fail_q;
         code_d = code_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         done_q <= 1'b0;
         fail_q <= 1'b0;
         code_q <= '0;
      end else begin
         done_q <= done_d;
         fail_q <= fail_d;
         code_q <= code_d;
      end
   end

   assign done_o     = done_q;
   assign fail_o     = fail_q;
   assign code_o     = code_q;
   assign hit_o      = hit_s;
   assign hit_fail_o = hit_s & hit_fail_s;
   assign hit_code_o = hit_code_s;

endmodule

// File: rtl/carp_run_ctrl.sv
// Run controller: holds core reset, runs the cores while counting cycles, ends on tohost pass/fail or timeout.
// Optional simulation report and $finish are enabled by defining CARP_RUN_FINISH_EN.
module carp_run_ctrl
   import carp_sim_pkg::*;
#(
   parameter int                NUM_HARTS      = 1,
   parameter int                ADDR_W         = 32,
   parameter int                DATA_W         = 32,
   parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(DEFAULT_TOHOST_ADDR),
   parameter int                RST_CYCLES     = 2,
   parameter int                TIMEOUT_CYCLES = 1000,
   parameter int                CNT_W          = 32
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          START,
   input  logic [NUM_HARTS-1:0]          MEM_WE,
   input  logic [NUM_HARTS*ADDR_W-1:0]   MEM_ADDR,
   input  logic [NUM_HARTS*DATA_W-1:0]   MEM_WDATA,
   output logic                          CORE_RST,
   output logic                          RUNNING,
   output logic                          DONE,
   output logic                          PASS,
   output logic                          TIMED_OUT,
   output logic [NUM_HARTS-1:0]          HART_DONE,
   output logic [DATA_W-1:0]             FAIL_CODE,
   output logic [CNT_W-1:0]              CYCLE_COUNT
);

   localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   run_state_t        state_q;
   logic [RC_W-1:0]   rst_cnt_q;
   logic              core_rst_q, running_q, done_q, pass_q, timed_out_q;
   logic [DATA_W-1:0] fail_code_q;
   logic [CNT_W-1:0]  cycle_count_q;

   logic                 run_s;
   logic [NUM_HARTS-1:0] hart_done_s, hart_fail_s, hart_hit_s, hart_hit_fail_s;
   logic [DATA_W-1:0]    hart_code_s     [NUM_HARTS];
   logic [DATA_W-1:0]    hart_hit_code_s [NUM_HARTS];
   logic [NUM_HARTS-1:0] hart_done_d;
   logic                 any_fail_d, failed_s, all_done_d;
   logic [DATA_W-1:0]    fail_code_d;

   assign run_s = (state_q == ST_RUN);

   for (genvar h = 0; h < NUM_HARTS; h++) begin : g_mon
      carp_tohost_mon #(
         .ADDR_W      (ADDR_W),
         .DATA_W      (DATA_W),
         .TOHOST_ADDR (TOHOST_ADDR)
      ) u_mon (
         .clk_i      (CLK),
         .rst_i      (RST),
         .en_i       (run_s),
         .we_i       (MEM_WE[h]),
         .addr_i     (MEM_ADDR[h*ADDR_W +: ADDR_W]),
         .wdata_i    (MEM_WDATA[h*DATA_W +: DATA_W]),
         .done_o     (hart_done_s[h]),
         .fail_o     (hart_fail_s[h]),
         .code_o     (hart_code_s[h]),
         .hit_o      (hart_hit_s[h]),
         .hit_fail_o (hart_hit_fail_s[h]),
         .hit_code_o (hart_hit_code_s[h])
      );
   end

   // Post-edge view of all harts; walking high-to-low leaves the lowest failing hart's code.
   always_comb begin
      hart_done_d = '0;
      any_fail_d  = 1'b0;
      failed_s    = 1'b0;
      fail_code_d = '0;
      for (int h = NUM_HARTS - 1; h >= 0; h--) begin
         hart_done_d[h] = hart_done_s[h] | hart_hit_s[h];
         failed_s       = hart_fail_s[h] | hart_hit_fail_s[h];
         any_fail_d     = any_fail_d | failed_s;
         fail_code_d    = failed_s ? (hart_done_s[h] ? hart_code_s[h] : hart_hit_code_s[h])
                                   : fail_code_d;
      end
      all_done_d = &hart_done_d;
   end

   // Run sequencer; completion is tested before the timeout so a last write on the final cycle wins.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= ST_IDLE;
         rst_cnt_q     <= '0;
         core_rst_q    <= 1'b1;
         running_q     <= 1'b0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         timed_out_q   <= 1'b0;
         fail_code_q   <= '0;
         cycle_count_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (START) begin
                  state_q       <= ST_RESET;
                  rst_cnt_q     <= '0;
                  cycle_count_q <= '0;
               end
            end
            ST_RESET: begin
               if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
                  state_q       <= ST_RUN;
                  core_rst_q    <= 1'b0;
                  running_q     <= 1'b1;
                  cycle_count_q <= '0;
               end else begin
                  rst_cnt_q <= rst_cnt_q + RC_W'(1);
               end
            end
            ST_RUN: begin
               if (all_done_d) begin
                  state_q     <= ST_DONE;
                  core_rst_q  <= 1'b1;
                  running_q   <= 1'b0;
                  done_q      <= 1'b1;
                  pass_q      <= ~any_fail_d;
                  fail_code_q <= fail_code_d;
               end else if (cycle_count_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  state_q     <= ST_TIMEOUT;
                  core_rst_q  <= 1'b1;
                  running_q   <= 1'b0;
                  done_q      <= 1'b1;
                  pass_q      <= 1'b0;
                  timed_out_q <= 1'b1;
                  fail_code_q <= fail_code_d;
               end else begin
                  cycle_count_q <= cycle_count_q + CNT_W'(1);
               end
            end
            ST_DONE, ST_TIMEOUT: begin
               state_q <= state_q;
            end
            default: begin
               state_q    <= ST_IDLE;
               core_rst_q <= 1'b1;
               running_q  <= 1'b0;
            end
         endcase
      end
   end

   assign CORE_RST    = core_rst_q;
   assign RUNNING     = running_q;
   assign DONE        = done_q;
   assign PASS        = pass_q;
   assign TIMED_OUT   = timed_out_q;
   assign HART_DONE   = hart_done_s;
   assign FAIL_CODE   = fail_code_q;
   assign CYCLE_COUNT = cycle_count_q;

`ifdef CARP_RUN_FINISH_EN
   logic reported_q, finish_q;

   // Simulation-only: report once on reaching a terminal state, then end the run a cycle later.
   always @(posedge CLK) begin
      if (RST) begin
         reported_q <= 1'b0;
         finish_q   <= 1'b0;
      end else begin
         if (finish_q) begin
            $finish;
         end
         if (is_terminal(state_q) && !reported_q) begin
            reported_q <= 1'b1;
            finish_q   <= 1'b1;
            $display("carp_run_ctrl: %s cycles=%0d fail_code=%0d hart_done=%b",
                     timed_out_q ? "TIMEOUT" : (pass_q ? "PASS" : "FAIL"),
                     cycle_count_q, fail_code_q, hart_done_s);
         end
      end
   end
`else
   // Synthesis build: no reporting logic.
`endif

endmodule

// File: doc/carp_run_ctrl.md
Name: carp_run_ctrl

Overview:
- Synthesizable run controller for CARP simulation and FPGA bring-up.
- Sequences core reset for a parametrised number of cycles, then runs the core(s) while counting cycles.
- Monitors each hart's data-store bus for RISC-V "tohost" completion writes and ends the run on pass, fail or timeout.
- Replaces hard-coded reset/finish delays in benches; sits between top-level CLK/RST and the CARP core reset input(s).

Parameters:
- NUM_HARTS, 1, number of monitored cores/store buses.
- ADDR_W, 32, store address width.
- DATA_W, 32, store data width.
- TOHOST_ADDR, 32'h0000_1000, completion mailbox address; compared at full ADDR_W.
- RST_CYCLES, 2, cycles CORE_RST is held after START; legal range ≥1.
- TIMEOUT_CYCLES, 1000, run-phase cycle budget; legal range ≥1.
- CNT_W, 32, cycle counter width; must hold TIMEOUT_CYCLES.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset of this block.
- START  in  1  level or pulse; sampled only in IDLE.
- MEM_WE  in  NUM_HARTS  per-hart store strobe.
- MEM_ADDR  in  NUM_HARTS*ADDR_W  per-hart store address, packed; hart h occupies [h*ADDR_W +: ADDR_W].
- MEM_WDATA  in  NUM_HARTS*DATA_W  per-hart store data, packed the same way.
- CORE_RST  out  1  reset to all cores, active-high.
- RUNNING  out  1  high in RUN.
- DONE  out  1  high in DONE or TIMEOUT; sticky until RST.
- PASS  out  1  valid when DONE; 1 means every hart passed.
- TIMED_OUT  out  1  high in TIMEOUT.
- HART_DONE  out  NUM_HARTS  per-hart latched completion.
- FAIL_CODE  out  DATA_W  code from the lowest-numbered failing hart; 0 if none.
- CYCLE_COUNT  out  CNT_W  run-phase cycles elapsed.

Behaviour:
- Reset (RST=1 at a CLK edge) puts the block in state IDLE with these values:
  - CORE_RST=1.
  - RUNNING, DONE, PASS, TIMED_OUT all 0.
  - HART_DONE=0, FAIL_CODE=0, CYCLE_COUNT=0.
- RST has priority over every other input in every state. RST mid-run aborts to IDLE and clears everything.
- FSM states: IDLE, RESET, RUN, DONE, TIMEOUT. All outputs are registered.
- IDLE:
  - CORE_RST=1.
  - START=1 moves to RESET; the reset-cycle counter loads 0.
- RESET:
  - CORE_RST=1; the counter increments.
  - After exactly RST_CYCLES cycles in RESET, move to RUN.
- RUN:
  - CORE_RST=0, RUNNING=1.
  - CYCLE_COUNT increments by 1 every RUN cycle, starting at 0 on the first RUN cycle.
- Tohost detection, per hart h, in RUN only:
  - A qualifying store is MEM_WE[h]=1 with address == TOHOST_ADDR.
  - Data==1: pass. Sets HART_DONE[h].
  - Odd data ≠1: fail with code = data>>1. Sets HART_DONE[h].
  - Even data: ignored.
  - The first qualifying write per hart wins. Later writes from a hart already done are ignored.
- All-harts-done:
  - When all HART_DONE bits would be set after this edge, move to DONE on the same edge.
  - In DONE: DONE=1, RUNNING=0, CORE_RST=1 (cores held).
  - PASS=1 iff no hart failed; otherwise FAIL_CODE is latched.
- Timeout:
  - If CYCLE_COUNT reaches TIMEOUT_CYCLES-1 without completion, the next edge moves to TIMEOUT.
  - In TIMEOUT: DONE=1, TIMED_OUT=1, PASS=0, CORE_RST=1.
- Simultaneous last tohost write and timeout edge: completion wins (DONE, not TIMEOUT).
- Simultaneous writes from multiple harts in the same cycle: all are latched.
- CYCLE_COUNT freezes on leaving RUN. DONE and TIMEOUT are terminal; only RST exits them.
- START outside IDLE is ignored.

Optional Feature:
- Macro CARP_RUN_FINISH_EN.
- Defined, simulation-only code (excluded from synthesis):
  - On entering DONE or TIMEOUT, $display a report: PASS/FAIL/TIMEOUT, CYCLE_COUNT, FAIL_CODE, HART_DONE.
  - Then call $finish one cycle later.
- Undefined: no system tasks. Behaviour is otherwise identical.

Decomposition:
- Shared package carp_sim_pkg holds:
  - run_state_t enum (IDLE, RESET, RUN, DONE, TIMEOUT).
  - Localparams TOHOST_PASS=1 and the default TOHOST_ADDR.
- One sub-module, carp_tohost_mon: a single-hart detector.
  - Inputs: enable, we, addr, wdata.
  - Outputs: done, fail, code, all latched.
  - Instantiated NUM_HARTS times via generate.

Test Plan:
- Reset/start sequencing:
  - RST=1 then 0, START pulsed 1 cycle, RST_CYCLES=2.
  - CORE_RST stays 1 exactly 2 cycles after START is sampled, then 0; RUNNING=1; CYCLE_COUNT counts 0,1,2…
- Single-hart pass:
  - At run cycle 10, MEM_WE=1, ADDR=0x1000, WDATA=1.
  - Next edge: DONE=1, PASS=1, CYCLE_COUNT=10, CORE_RST=1.
- Fail plus ignored writes:
  - WDATA=0x2 (even) at 0x1000 → ignored.
  - Then WDATA=0x7 → DONE=1, PASS=0, FAIL_CODE=3.
  - Write to 0x1004 beforehand → no effect.
- Timeout:
  - TIMEOUT_CYCLES=20, no tohost writes.
  - After 20 run cycles: TIMED_OUT=1, DONE=1, PASS=0, CYCLE_COUNT=19.
  - Variant: last write on cycle 19 → DONE with PASS, TIMED_OUT=0.
- Multi-hart (NUM_HARTS=2):
  - Hart0 writes 1 at cycle 5 → HART_DONE=01, still RUNNING.
  - Hart1 writes 5 at cycle 9 → DONE=1, PASS=0, FAIL_CODE=2.
  - Simultaneous-write variant: both harts write in the same cycle, both latched, DONE next edge.
- Mid-run reset:
  - RST=1 during RUN at cycle 7.
  - Next edge: all outputs at reset values.
  - A new START re-runs cleanly with CYCLE_COUNT restarting at 0.
